// File: rtl/tt_sweep_pkg.sv
// Shared constants for the truth-table sweeper: state encoding, table depth helper, settle default.
package tt_sweep_pkg;

   typedef logic [1:0] sweepState_t;

   localparam sweepState_t StIdle   = 2'd0;
   localparam sweepState_t StDrive  = 2'd1;
   localparam sweepState_t StSample = 2'd2;
   localparam sweepState_t StFinish = 2'd3;

   localparam int unsigned DefaultSettle = 1;
   localparam int unsigned SettleWidth   = 4;

   function automatic int unsigned ttDepth(input int unsigned nInputs);
      return 2 ** nInputs;
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module tt_settle_timer
   import tt_sweep_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [SettleWidth-1:0] loadValue,
   input  logic                   dec,
   output logic                   expired
);

   logic [SettleWidth-1:0] countQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         countQ <= '0;
      end else if (load) begin
         countQ <= loadValue;
      end else if (dec && !expired) begin
         countQ <= countQ - 1'b1;
      end
   end

   assign expired = (countQ == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector, samples s_in after a settle time and builds the truth table.
// Optional golden-table compare enabled by defining TT_SWEEP_CHECK_EN.
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int unsigned N_INPUTS      = 4,
   parameter int unsigned SETTLE_CYCLES = DefaultSettle
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   output logic [N_INPUTS-1:0]             vec_out,
   input  logic                            s_in,
   output logic                            busy,
   output logic                            done,
   output logic [ttDepth(N_INPUTS)-1:0]    table_out,
   output logic [N_INPUTS:0]               ones_count
`ifdef TT_SWEEP_CHECK_EN
   ,
   input  logic [ttDepth(N_INPUTS)-1:0]    expected,
   output logic                            mismatch,
   output logic [N_INPUTS-1:0]             first_bad
`endif
);

   localparam int unsigned Depth = ttDepth(N_INPUTS);
   localparam logic [N_INPUTS-1:0] LastVec = N_INPUTS'(Depth - 1);

   sweepState_t stateQ, stateD;
   logic [N_INPUTS-1:0] vecQ, vecD;
   logic busyQ, busyD, doneQ, doneD;
   logic [Depth-1:0] tableQ, tableD;
   logic [N_INPUTS:0] onesQ, onesD;
   logic timerLoad, timerExpired;

`ifdef TT_SWEEP_CHECK_EN
   logic mismatchQ, mismatchD;
   logic [N_INPUTS-1:0] firstBadQ, firstBadD;
`endif

   // Loaded with SETTLE_CYCLES-1 so DRIVE lasts exactly SETTLE_CYCLES cycles.
   tt_settle_timer uTimer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (timerLoad),
      .loadValue (SettleWidth'(SETTLE_CYCLES - 1)),
      .dec       (stateQ == StDrive),
      .expired   (timerExpired)
   );

   always_comb begin
      stateD    = stateQ;
      vecD      = vecQ;
      busyD     = busyQ;
      doneD     = 1'b0;
      tableD    = tableQ;
      onesD     = onesQ;
      timerLoad = 1'b0;
`ifdef TT_SWEEP_CHECK_EN
      mismatchD = mismatchQ;
      firstBadD = firstBadQ;
`endif
      unique case (stateQ)
         StIdle: begin
            if (start) begin
               stateD    = StDrive;
               vecD      = '0;
               busyD     = 1'b1;
               tableD    = '0;
               onesD     = '0;
               timerLoad = 1'b1;
`ifdef TT_SWEEP_CHECK_EN
               mismatchD = 1'b0;
               firstBadD = '0;
`endif
            end
         end
         StDrive: begin
            if (timerExpired) stateD = StSample;
         end
         StSample: begin
            tableD[vecQ] = s_in;
            onesD        = onesQ + (N_INPUTS + 1)'(s_in);
`ifdef TT_SWEEP_CHECK_EN
            if (s_in != expected[vecQ]) begin
               mismatchD = 1'b1;
               if (!mismatchQ) firstBadD = vecQ;
            end
`endif
            // Terminal compare keeps vec_out from wrapping past the last vector.
            if (vecQ == LastVec) begin
               stateD = StFinish;
               busyD  = 1'b0;
               doneD  = 1'b1;
            end else begin
               stateD    = StDrive;
               vecD      = vecQ + 1'b1;
               timerLoad = 1'b1;
            end
         end
         StFinish: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StIdle;
         vecQ   <= '0;
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
         tableQ <= '0;
         onesQ  <= '0;
      end else begin
         stateQ <= stateD;
         vecQ   <= vecD;
         busyQ  <= busyD;
         doneQ  <= doneD;
         tableQ <= tableD;
         onesQ  <= onesD;
      end
   end

`ifdef TT_SWEEP_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatchQ <= 1'b0;
         firstBadQ <= '0;
      end else begin
         mismatchQ <= mismatchD;
         firstBadQ <= firstBadD;
      end
   end

   assign mismatch  = mismatchQ;
   assign first_bad = firstBadQ;
`endif

   assign vec_out    = vecQ;
   assign busy       = busyQ;
   assign done       = doneQ;
   assign table_out  = tableQ;
   assign ones_count = onesQ;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Upstream stimulus/capture stage for the 4-input combinational boolean function blocks (one output `s`, inputs a,b,c,d).
- On `start`, walks the input vector 0..2^N_INPUTS-1, holds each vector for a settle time, samples the function output, and stores it in a truth-table register.
- Reports done, the full table and the number of true minterms.
- Replaces ad-hoc testbench loops with synthesizable, clocked characterisation hardware.

Parameters:
- N_INPUTS, 4, width of the driven input vector; vec_out[N_INPUTS-1] maps to `a`, bit 0 maps to `d`.
- SETTLE_CYCLES, 1, cycles the vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored unless idle.
- vec_out  out  N_INPUTS  vector driven to the function under test.
- s_in  in  1  function output being sampled.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sweep completes.
- table_out  out  2^N_INPUTS  bit k holds the sampled s_in for vec_out==k.
- ones_count  out  N_INPUTS+1  number of 1 bits in table_out.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; vec_out=0, busy=0, done=0, table_out=0, ones_count=0, settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE, start=1: clear table_out and ones_count, vec_out=0, settle counter=0, go to DRIVE; busy=1 from the next cycle.
- DRIVE: increment the settle counter each cycle. When the counter reaches SETTLE_CYCLES-1, go to SAMPLE. The vector is held for exactly SETTLE_CYCLES cycles.
- SAMPLE, one cycle:
  - table_out[vec_out] <= s_in; ones_count += s_in.
  - If vec_out == 2^N_INPUTS-1, go to FINISH and leave vec_out at its last value.
  - Otherwise vec_out++, clear the settle counter and go to DRIVE.
- FINISH, one cycle: done=1, busy=0, then go to IDLE. table_out and ones_count hold until the next accepted start.
- Total latency from start to done: 2^N_INPUTS*(SETTLE_CYCLES+1)+1 cycles. For the defaults, start accepted at cycle 0 gives done at cycle 33.
- start while busy or in FINISH: ignored, with no restart and no queueing.
- start in the same cycle as the done pulse: ignored. A new start is accepted only in IDLE.
- vec_out is a registered output and changes only on entry to DRIVE. The vector does not wrap during a sweep; the terminal compare prevents overflow.
- Reset mid-sweep: immediate return to reset values and the partial table is discarded.
- ones_count must never exceed 2^N_INPUTS; its width N_INPUTS+1 holds the full count.

Optional Feature:
- Macro: TT_SWEEP_CHECK_EN.
- When defined:
  - Adds input `expected` (2^N_INPUTS bits) and outputs `mismatch` (1) and `first_bad` (N_INPUTS).
  - At each SAMPLE where s_in != expected[vec_out], set the sticky `mismatch` and, on the first failure only, latch `first_bad`=vec_out.
  - Both clear on reset and on an accepted start.
- When undefined: these ports and this logic are absent; all other behaviour is identical.

Decomposition:
- Package tt_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, FINISH) in a 2-bit encoding;
  - the TT_DEPTH = 2**N_INPUTS helper function;
  - the default settle constant.
- One natural sub-module: tt_settle_timer, a loadable down-counter that asserts `expired`. The main block instantiates it once.

Test Plan:
- Reset with no start for 10 cycles: busy=0, done=0, vec_out=0, table_out=0, ones_count=0 throughout.
- Connect the existing 4-input f7 function (a=vec_out[3] .. d=vec_out[0]) and pulse start: done at cycle 33, table_out=16'h7310, ones_count=6.
- s_in tied to 1, SETTLE_CYCLES=3: done at cycle 4*16+1=65, table_out=16'hFFFF, ones_count=16.
- start re-pulsed at cycles 5 and 20 during a sweep, and again coincident with done: no restart, done still at cycle 33, with one pulse only.
- rst_n asserted at cycle 17 mid-sweep, then start: outputs return to 0 immediately; the new sweep completes 33 cycles after the new start with the correct table.
- With TT_SWEEP_CHECK_EN, expected=16'h7310 against the f7 function: mismatch=0. With expected=16'h7311: mismatch=1, first_bad=0.
